fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
Round-robin write-port arbiter that shares the single write port of async_fifo among NUM_REQ producers in the write clock domain. Each producer uses a valid/ready handshake. The arbiter grants one owner at a time, for a bounded burst, and gates writes on the FIFO full flag. It sits directly in front of async_fifo's wr_data, wr_en and full pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 8, word width; must equal async_fifo DATA_WIDTH.
MAX_BURST, 4, maximum consecutive accepted words per grant (1..16).

Ports:
wr_clk  input  1  write-domain clock.
rst_n  input  1  reset; asynchronous, active-low.
enable  input  1  arbitration enable.
req_valid  input  NUM_REQ  per-requester word-valid.
req_data  input  NUM_REQ*DATA_WIDTH  requester i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  per-requester accept; a word transfers when valid & ready.
fifo_full  input  1  async_fifo full.
fifo_wr_en  output  1  to async_fifo wr_en.
fifo_wr_data  output  DATA_WIDTH  to async_fifo wr_data.
grant_id  output  clog2(NUM_REQ)  current or last owner index (registered).
busy  output  1  high while in OWN.
write_count  output  16  total words written; wraps at 16'hFFFF -> 0.

Behaviour:
- Clock, reset and reset values:
  - Single clock wr_clk. Reset is asynchronous, active-low (rst_n).
  - Reset values: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0, write_count=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- FSM states: IDLE, OWN.
- IDLE:
  - If enable=1 and any req_valid is set, select the first set bit searching i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: grant_id <= i, burst_cnt <= 0, state <= OWN.
  - No transfer occurs in IDLE. Arbitration latency is 1 cycle.
- OWN (combinational outputs):
  - req_ready[grant_id] = enable & ~fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[grant_id] & req_ready[grant_id].
  - fifo_wr_data = req_data slice of grant_id, muxed combinationally. Drive 0 when fifo_wr_en=0.
- OWN (on each transfer): burst_cnt++ and write_count++.
- OWN release conditions, evaluated at the edge; on release rr_ptr <= grant_id+1 mod NUM_REQ and state <= IDLE:
  - A transfer occurs with burst_cnt == MAX_BURST-1.
  - enable=0.
  - req_valid[grant_id]=0 while fifo_full=0.
- Stall rules:
  - While fifo_full=1 the owner holds the grant indefinitely; burst_cnt is frozen and there is no timeout.
  - The owner holds a frozen burst_cnt even if it drops valid during full.
- Producer contract: keep valid and data stable until ready. The arbiter does not check this.
- Fairness: every release produces one IDLE bubble cycle. Max wait for a continuously-valid requester is (NUM_REQ-1)*(MAX_BURST+1) non-full cycles.
- Full behaviour: full is sampled combinationally, so no write is issued while full=1. A write that makes the FIFO full is legal; the following cycle is blocked.
- Reset mid-burst: everything returns to reset values immediately. The partially granted burst is abandoned. No fifo_wr_en is issued during or after reset until a new grant.
- grant_id holds its last value in IDLE.

Test Plan:
- Only req_valid[1]=1, 3 words (A1,A2,A3), enable=1, fifo_full=0.
  - Response: busy rises 1 cycle later with grant_id=1.
  - fifo_wr_en high for 3 consecutive cycles with data A1,A2,A3.
  - valid drop -> IDLE. write_count=3, rr_ptr=2.
- All 4 requesters continuously valid, MAX_BURST=4, from reset.
  - Response: grant order 0,1,2,3,0.
  - Each owner gets exactly 4 writes followed by 1 bubble cycle: 20 writes in 25 cycles.
- Owner 0 mid-burst after 2 writes, fifo_full=1 for 5 cycles.
  - Response: fifo_wr_en=0 and req_ready=0 for 5 cycles; grant_id stays 0.
  - After full clears, exactly 2 more writes, then release.
- After owner 2 releases, req_valid=4'b0101.
  - Response: next grant is 0 (search wraps from rr_ptr=3), then 2, skipping idle requesters 1 and 3.
- enable deasserted in OWN cycle with valid=1.
  - Response: no write in that cycle; IDLE next edge. No new grant while enable=0; arbitration resumes when enable=1.
- rst_n pulled low asynchronously mid-burst (grant_id=2, write_count=7).
  - Response: all outputs 0 immediately, without waiting for a clock edge.
  - After release with all valid, first grant is 0 and write_count restarts from 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async_fifo write port among NUM_REQ valid/ready producers.
// A grant lasts at most MAX_BURST words and is held, frozen, while the FIFO is full.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; pick the next valid requester from rr_ptr onward
//   OWN     | grant_id owns the write port until burst end, drop or disable
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                          wr_clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy,
   output logic [15:0]                   write_count
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_OWN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [GW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [BW-1:0] burst_q, burst_d;
   logic [15:0]   wcount_q, wcount_d;

   logic                  pick_found;
   logic [GW-1:0]         pick_idx;
   int                    idx_int;
   logic                  own_valid;
   logic [DATA_WIDTH-1:0] own_data;
   logic                  own_ready;
   logic                  xfer;
   logic                  release_own;

   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      idx_int    = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_int = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (req_valid[idx_int[GW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = idx_int[GW-1:0];
         end
      end
   end

   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == GW'(i)) begin
            own_valid = req_valid[i];
            own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign own_ready = (state_q == ST_OWN) && enable && !fifo_full;
   assign xfer      = own_ready && own_valid;

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = own_ready && (grant_q == GW'(i));
      end
   end

   assign fifo_wr_en   = xfer;
   assign fifo_wr_data = xfer ? own_data : '0;
   assign grant_id     = grant_q;
   assign busy         = (state_q == ST_OWN);
   assign write_count  = wcount_q;

   // A valid drop only ends the grant when the FIFO is not full; during full the owner keeps it.
   assign release_own = (xfer && (burst_q == BW'(MAX_BURST - 1)))
                      || !enable
                      || (!own_valid && !fifo_full);

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      burst_d  = burst_q;
      wcount_d = wcount_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && pick_found) begin
               grant_d = pick_idx;
               burst_d = '0;
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            if (xfer) begin
               burst_d  = burst_q + BW'(1);
               wcount_d = wcount_q + 16'd1;
            end
            if (release_own) begin
               rr_ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + GW'(1);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         burst_q  <= '0;
         wcount_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         burst_q  <= burst_d;
         wcount_q <= wcount_d;
      end
   end

endmodule
